lut_sweep_engine: RTL and testbench

LUT_SWEEP_ENGINE -- requirements
Module: lut_sweep_engine

---
 rtl/lut_sweep_engine.sv | 107 ++++++++++
 tb/tb_lut_sweep_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_sweep_engine.sv
// Bank of NOUT programmable NIN-input truth tables, evaluated on demand or
// swept over every input vector in ascending order behind a valid/ready output.
module lut_sweep_engine #(
  parameter  int NIN   = 4,
  parameter  int NOUT  = 10,
  localparam int FN_W  = (NOUT > 1) ? $clog2(NOUT) : 1,
  localparam int DEPTH = 1 << NIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [FN_W-1:0]   cfg_fn,
  input  logic [DEPTH-1:0]  cfg_tbl,
  input  logic              in_valid,
  input  logic [NIN-1:0]    in_vec,
  output logic              in_ready,
  input  logic              sweep_start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NIN-1:0]    out_idx,
  output logic [NOUT-1:0]   out_vec
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [FN_W:0] FN_LIMIT = (FN_W + 1)'(NOUT);

  state_t            state, state_next;
  logic [NIN-1:0]    cnt;
  logic              cnt_last;
  logic [DEPTH-1:0]  tbl [NOUT];
  logic              eval_load, sweep_load, cfg_write;
  logic [NIN-1:0]    eval_idx;
  logic [NOUT-1:0]   eval_vec;

  assign cnt_last = (cnt == {NIN{1'b1}});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is also what makes a same-cycle write and
  // evaluate read the old table contents.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sweep_start) state_next = SWEEP;
      SWEEP:   if (sweep_load && cnt_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == SWEEP);
    in_ready   = (state == IDLE) && !sweep_start && (!out_valid || out_ready);
    eval_load  = in_valid && in_ready;
    sweep_load = (state == SWEEP) && (!out_valid || out_ready);
    cfg_write  = cfg_we && (state == IDLE) && ({1'b0, cfg_fn} < FN_LIMIT);
  end

  // During a sweep the counter drives the lookup; otherwise the request does.
  assign eval_idx = busy ? cnt : in_vec;

  always_comb begin
    eval_vec = '0;
    for (int k = 0; k < NOUT; k++) eval_vec[k] = tbl[k][eval_idx];
  end

  // NOTE: the tables are flip-flops that must read as zero after reset, so
  // they are cleared explicitly rather than left to power-up state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NOUT; k++) tbl[k] <= '0;
    end else if (cfg_write) begin
      tbl[cfg_fn] <= cfg_tbl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_vec   <= '0;
    end else begin
      done <= sweep_load && cnt_last;
      // The counter stops on the last vector; the next sweep clears it.
      if ((state == IDLE) && sweep_start)  cnt <= '0;
      else if (sweep_load && !cnt_last)    cnt <= cnt + 1'b1;
      if (eval_load || sweep_load) begin
        out_valid <= 1'b1;
        out_idx   <= eval_idx;
        out_vec   <= eval_vec;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lut_sweep_engine.sv
// Scoreboard bench for lut_sweep_engine: a truth-table model predicts every
// output beat, and a negedge monitor pops and compares at each handshake.
module tb_lut_sweep_engine;

  localparam int NIN   = 4;
  localparam int NOUT  = 10;
  localparam int FN_W  = 4;
  localparam int DEPTH = 16;

  logic              clk;
  logic              rst;
  logic              cfg_we;
  logic [FN_W-1:0]   cfg_fn;
  logic [DEPTH-1:0]  cfg_tbl;
  logic              in_valid;
  logic [NIN-1:0]    in_vec;
  logic              in_ready;
  logic              sweep_start;
  logic              busy;
  logic              done;
  logic              out_valid;
  logic              out_ready;
  logic [NIN-1:0]    out_idx;
  logic [NOUT-1:0]   out_vec;

  lut_sweep_engine #(.NIN(NIN), .NOUT(NOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_fn      (cfg_fn),
    .cfg_tbl     (cfg_tbl),
    .in_valid    (in_valid),
    .in_vec      (in_vec),
    .in_ready    (in_ready),
    .sweep_start (sweep_start),
    .busy        (busy),
    .done        (done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_vec     (out_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NIN-1:0]  idx;
    logic [NOUT-1:0] vec;
  } beat_t;

  beat_t            exp_q[$];
  beat_t            mon_exp;
  logic [DEPTH-1:0] model_tbl [NOUT];
  int               n_checks = 0;
  int               n_pass   = 0;

  logic             prev_stall = 1'b0;
  logic [NIN-1:0]   prev_idx;
  logic [NOUT-1:0]  prev_vec;

  function automatic logic [NOUT-1:0] model_eval(input logic [NIN-1:0] v);
    logic [NOUT-1:0] r;
    for (int k = 0; k < NOUT; k++) r[k] = model_tbl[k][v];
    return r;
  endfunction

  // Output monitor: stall stability and in-order scoreboard comparison.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== prev_idx || out_vec !== prev_vec)
          $display("FAIL hold: valid=%b idx=%0d vec=%h, required valid=1 idx=%0d vec=%h",
                   out_valid, out_idx, out_vec, prev_idx, prev_vec);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat_unexpected: idx=%0d vec=%h with empty scoreboard", out_idx, out_vec);
        end else begin
          mon_exp = exp_q.pop_front();
          if (out_idx !== mon_exp.idx || out_vec !== mon_exp.vec)
            $display("FAIL beat: idx=%0d vec=%h, required idx=%0d vec=%h",
                     out_idx, out_vec, mon_exp.idx, mon_exp.vec);
          else n_pass++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_idx   = out_idx;
      prev_vec   = out_vec;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_eval(input logic [NIN-1:0] v);
    beat_t b;
    b.idx = v;
    b.vec = model_eval(v);
    exp_q.push_back(b);
  endtask

  task automatic cfg_write(input int fn, input logic [DEPTH-1:0] t);
    cfg_we  = 1'b1;
    cfg_fn  = FN_W'(fn);
    cfg_tbl = t;
    tick();
    cfg_we  = 1'b0;
    if (fn < NOUT) model_tbl[fn] = t;
  endtask

  task automatic start_sweep();
    sweep_start = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_eval(NIN'(i));
    tick();
    sweep_start = 1'b0;
  endtask

  // Watches a sweep until done (bounded); optionally randomises out_ready.
  task automatic wait_sweep(input bit rand_ready, output int busy_cyc, output int valid_cyc,
                            output int rdy_busy, output int done_cnt,
                            output logic [NIN-1:0] done_idx);
    busy_cyc = 0; valid_cyc = 0; rdy_busy = 0; done_cnt = 0; done_idx = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (out_valid) valid_cyc++;
      if (busy && in_ready) rdy_busy++;
      if (done) begin
        done_cnt++;
        done_idx = out_idx;
        break;
      end
      if (rand_ready) begin
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 1'b0; cfg_fn = '0; cfg_tbl = '0; in_valid = 1'b0;
    in_vec = '0; sweep_start = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < NOUT; k++) model_tbl[k] = '0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_idx !== '0) $display("FAIL reset_out_idx: got %0d want 0", out_idx); else n_pass++;
    n_checks++; if (out_vec !== '0) $display("FAIL reset_out_vec: got %h want 0", out_vec); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_eval();
    tick();
    cfg_write(0, 16'hAAAA);
    cfg_write(1, 16'hFF00);
    in_valid = 1'b1;
    in_vec   = 4'b1011;
    push_eval(4'b1011);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL eval_in_ready: got %b want 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL eval_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_idx !== 4'd11) $display("FAIL eval_idx: got %0d want 11", out_idx); else n_pass++;
    n_checks++; if (out_vec !== 10'h003) $display("FAIL eval_vec: got %h want 003", out_vec); else n_pass++;
  endtask

  task automatic test_write_eval_same();
    tick();
    cfg_we = 1'b1; cfg_fn = 4'd2; cfg_tbl = 16'h8000;
    in_valid = 1'b1; in_vec = 4'hF;
    push_eval(4'hF);
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    model_tbl[2] = 16'h8000;
    @(negedge clk);
    n_checks++; if (out_vec !== 10'h003) $display("FAIL same_cycle_vec: got %h want 003", out_vec); else n_pass++;
    tick();
    in_valid = 1'b1; in_vec = 4'hF;
    push_eval(4'hF);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_vec !== 10'h007) $display("FAIL reeval_vec: got %h want 007", out_vec); else n_pass++;
  endtask

  task automatic test_sweep_ready();
    int bc, vc, rb, dc;
    logic [NIN-1:0] di;
    tick();
    out_ready = 1'b1;
    start_sweep();
    wait_sweep(1'b0, bc, vc, rb, dc, di);
    n_checks++; if (bc != 16) $display("FAIL sweep_busy_cycles: got %0d want 16", bc); else n_pass++;
    n_checks++; if (vc != 16) $display("FAIL sweep_valid_beats: got %0d want 16", vc); else n_pass++;
    n_checks++; if (rb != 0) $display("FAIL sweep_in_ready: got %0d cycles want 0", rb); else n_pass++;
    n_checks++; if (dc != 1) $display("FAIL sweep_done: got %0d pulses want 1", dc); else n_pass++;
    n_checks++; if (di !== 4'd15) $display("FAIL sweep_done_idx: got %0d want 15", di); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL sweep_after: done=%b busy=%b want 0 0", done, busy); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL sweep_drain: %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_sweep_stall();
    int bc, vc, rb, dc;
    logic [NIN-1:0] di;
    tick();
    start_sweep();
    wait_sweep(1'b1, bc, vc, rb, dc, di);
    #1;
    out_ready = 1'b1;
    repeat (3) tick();
    n_checks++; if (dc != 1) $display("FAIL stall_done: got %0d pulses want 1", dc); else n_pass++;
    n_checks++; if (di !== 4'd15) $display("FAIL stall_done_idx: got %0d want 15", di); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL stall_drain: %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    bit found = 1'b0;
    int done_seen = 0;
    tick();
    out_ready = 1'b1;
    start_sweep();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid && out_idx == 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++; if (!found) $display("FAIL midrst_reach7: got 0 want 1"); else n_pass++;
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NOUT; k++) model_tbl[k] = '0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_vec !== '0) $display("FAIL midrst_vec: got %h want 0", out_vec); else n_pass++;
    repeat (20) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    n_checks++; if (done_seen != 0) $display("FAIL midrst_done: got %0d pulses want 0", done_seen); else n_pass++;
    tick();
    in_valid = 1'b1; in_vec = 4'hF;
    push_eval(4'hF);
    tick();
    in_vec = 4'h5;
    push_eval(4'h5);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_vec !== '0)
      $display("FAIL midrst_tables: valid=%b vec=%h want 1 000", out_valid, out_vec); else n_pass++;
  endtask

  task automatic test_ignored_writes();
    int bc, vc, rb, dc;
    logic [NIN-1:0] di;
    tick();
    cfg_write(0, 16'h1234);
    cfg_write(3, 16'hBEEF);
    cfg_write(9, 16'h0F0F);
    cfg_we = 1'b1; cfg_tbl = 16'hFFFF; cfg_fn = 4'd12;
    tick();
    cfg_fn = 4'd15;
    tick();
    cfg_we = 1'b0;
    start_sweep();
    cfg_we = 1'b1; cfg_fn = 4'd0; cfg_tbl = 16'hFFFF; sweep_start = 1'b1;
    repeat (4) tick();
    cfg_we = 1'b0; sweep_start = 1'b0;
    wait_sweep(1'b0, bc, vc, rb, dc, di);
    n_checks++; if (dc != 1 || di !== 4'd15)
      $display("FAIL ign_sweep1: done=%0d idx=%0d want 1 15", dc, di); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL ign_restart: busy=%b want 0", busy); else n_pass++;
    tick();
    start_sweep();
    wait_sweep(1'b0, bc, vc, rb, dc, di);
    n_checks++; if (dc != 1) $display("FAIL ign_sweep2: got %0d pulses want 1", dc); else n_pass++;
    repeat (2) tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL ign_drain: %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bc, vc, rb, dc;
    logic [NIN-1:0] di;
    tick();
    start_sweep();
    wait_sweep(1'b0, bc, vc, rb, dc, di);
    n_checks++; if (dc != 1) $display("FAIL b2b_first_done: got %0d want 1", dc); else n_pass++;
    #1;
    sweep_start = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_eval(NIN'(i));
    tick();
    sweep_start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else n_pass++;
    wait_sweep(1'b0, bc, vc, rb, dc, di);
    n_checks++; if (dc != 1 || di !== 4'd15)
      $display("FAIL b2b_second_done: done=%0d idx=%0d want 1 15", dc, di); else n_pass++;
    repeat (2) tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_drain: %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_eval();
    test_write_eval_same();
    test_sweep_ready();
    test_sweep_stall();
    test_reset_mid_sweep();
    test_ignored_writes();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
